// File: rtl/ibex_rf_cache_fill_ctrl.sv
// Fill controller for a small register-file cache: captures A/B/W misses, fetches from the
// backing file and writes lines round-robin. Optional IBEX_RF_CACHE_PERF_EN adds perf counters.
module ibex_rf_cache_fill_ctrl #(
    parameter int unsigned CacheLen  = 16,
    parameter int unsigned DataWidth = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        miss_a_i,
    input  logic [4:0]                  addr_a_i,
    input  logic                        miss_b_i,
    input  logic [4:0]                  addr_b_i,
    input  logic                        wmiss_i,
    input  logic [4:0]                  waddr_i,
    input  logic [DataWidth-1:0]        wdata_i,
    output logic                        bk_req_o,
    output logic [4:0]                  bk_addr_o,
    input  logic                        bk_rvalid_i,
    input  logic [DataWidth-1:0]        bk_rdata_i,
    output logic                        cw_en_o,
    output logic [$clog2(CacheLen)-1:0] cw_way_o,
    output logic [4:0]                  cw_tag_o,
    output logic [DataWidth-1:0]        cw_data_o,
    input  logic                        flush_i,
`ifdef IBEX_RF_CACHE_PERF_EN
    output logic [31:0]                 perf_miss_cnt_o,
    output logic [31:0]                 perf_stall_cnt_o,
`endif
    output logic                        stall_o
);

    localparam int unsigned     WayW    = $clog2(CacheLen);
    localparam logic [WayW-1:0] LastWay = WayW'(CacheLen - 1);
    localparam logic [1:0]      IdxA    = 2'd0;
    localparam logic [1:0]      IdxB    = 2'd1;
    localparam logic [1:0]      IdxW    = 2'd2;
    localparam logic [1:0]      IdxNone = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FILL = 2'd3
    } state_e;

    function automatic logic [1:0] f_first(input logic [2:0] vld);
        logic [1:0] idx;
        if (vld[0]) begin
            idx = IdxA;
        end else if (vld[1]) begin
            idx = IdxB;
        end else if (vld[2]) begin
            idx = IdxW;
        end else begin
            idx = IdxNone;
        end
        return idx;
    endfunction

    function automatic logic [4:0] f_pick(input logic [2:0][4:0] addr, input logic [1:0] idx);
        logic [4:0] res;
        case (idx)
            2'd0:    res = addr[0];
            2'd1:    res = addr[1];
            2'd2:    res = addr[2];
            default: res = 5'd0;
        endcase
        return res;
    endfunction

    state_e                r_state;
    logic [2:0]            r_pend_vld;
    logic [2:0][4:0]       r_pend_addr;
    logic [DataWidth-1:0]  r_wdata;
    logic [4:0]            r_cur_addr;
    logic [DataWidth-1:0]  r_cur_data;
    logic [WayW-1:0]       r_victim;

    state_e                w_state_nxt;
    logic [2:0]            w_pend_vld_nxt;
    logic [2:0][4:0]       w_pend_addr_nxt;
    logic [DataWidth-1:0]  w_wdata_nxt;
    logic [4:0]            w_cur_addr_nxt;
    logic [DataWidth-1:0]  w_cur_data_nxt;
    logic [WayW-1:0]       w_victim_nxt;

    logic                  w_cap_a;
    logic                  w_cap_b;
    logic                  w_cap_w;
    logic                  w_cap_any;
    logic [2:0]            w_new_vld;
    logic [2:0][4:0]       w_new_addr;
    logic [1:0]            w_sel_new;
    logic [1:0]            w_sel_pend;
    logic                  w_cw_en;

    // B folds into A when both target the same register; address 0 never needs a fill.
    assign w_cap_a    = miss_a_i && (addr_a_i != 5'd0);
    assign w_cap_b    = miss_b_i && (addr_b_i != 5'd0) && !(w_cap_a && (addr_a_i == addr_b_i));
    assign w_cap_w    = wmiss_i && (waddr_i != 5'd0);
    assign w_cap_any  = rst_ni && (r_state == ST_IDLE) && !flush_i && (w_cap_a || w_cap_b || w_cap_w);
    assign w_new_vld  = {w_cap_w, w_cap_b, w_cap_a};
    assign w_new_addr = {waddr_i, addr_b_i, addr_a_i};
    assign w_sel_new  = f_first(w_new_vld);
    assign w_sel_pend = f_first(r_pend_vld);
    assign w_cw_en    = (r_state == ST_FILL) && !flush_i;

    // Next-state and datapath selection for the fill sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_addr_nxt = r_pend_addr;
        w_wdata_nxt     = r_wdata;
        w_cur_addr_nxt  = r_cur_addr;
        w_cur_data_nxt  = r_cur_data;
        w_victim_nxt    = r_victim;
        if (flush_i) begin
            w_state_nxt    = ST_IDLE;
            w_pend_vld_nxt = 3'b000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cap_any) begin
                        w_pend_vld_nxt  = w_new_vld & ~(3'b001 << w_sel_new);
                        w_pend_addr_nxt = w_new_addr;
                        w_wdata_nxt     = wdata_i;
                        w_cur_addr_nxt  = f_pick(w_new_addr, w_sel_new);
                        if (w_sel_new == IdxW) begin
                            w_state_nxt    = ST_FILL;
                            w_cur_data_nxt = wdata_i;
                        end else begin
                            w_state_nxt = ST_REQ;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (bk_rvalid_i) begin
                        w_state_nxt    = ST_FILL;
                        w_cur_data_nxt = bk_rdata_i;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_FILL: begin
                    w_victim_nxt   = (r_victim == LastWay) ? {WayW{1'b0}} : r_victim + WayW'(1);
                    w_pend_vld_nxt = r_pend_vld & ~(3'b001 << w_sel_pend);
                    w_cur_addr_nxt = f_pick(r_pend_addr, w_sel_pend);
                    if (w_sel_pend == IdxNone) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_sel_pend == IdxW) begin
                        w_state_nxt    = ST_FILL;
                        w_cur_data_nxt = r_wdata;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_pend_vld_nxt = 3'b000;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_pend_vld  <= 3'b000;
            r_pend_addr <= '{default: 5'd0};
            r_wdata     <= {DataWidth{1'b0}};
            r_cur_addr  <= 5'd0;
            r_cur_data  <= {DataWidth{1'b0}};
            r_victim    <= {WayW{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_addr <= w_pend_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_cur_addr  <= w_cur_addr_nxt;
            r_cur_data  <= w_cur_data_nxt;
            r_victim    <= w_victim_nxt;
        end
    end

    // Outputs are qualified by state so idle and reset present all-zero buses.
    assign stall_o   = rst_ni && ((r_state != ST_IDLE) || w_cap_any);
    assign bk_req_o  = (r_state == ST_REQ);
    assign bk_addr_o = (r_state == ST_REQ) ? r_cur_addr : 5'd0;
    assign cw_en_o   = w_cw_en;
    assign cw_way_o  = w_cw_en ? r_victim : {WayW{1'b0}};
    assign cw_tag_o  = w_cw_en ? r_cur_addr : 5'd0;
    assign cw_data_o = w_cw_en ? r_cur_data : {DataWidth{1'b0}};

`ifdef IBEX_RF_CACHE_PERF_EN
    logic [31:0] r_perf_miss;
    logic [31:0] r_perf_stall;

    // Saturating event counters for line writes and stall cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_miss  <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (w_cw_en && (r_perf_miss != 32'hFFFF_FFFF)) begin
                r_perf_miss <= r_perf_miss + 32'd1;
            end else begin
                r_perf_miss <= r_perf_miss;
            end
            if (stall_o && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end else begin
                r_perf_stall <= r_perf_stall;
            end
        end
    end

    assign perf_miss_cnt_o  = r_perf_miss;
    assign perf_stall_cnt_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_ibex_rf_cache_fill_ctrl.sv
// Bench for ibex_rf_cache_fill_ctrl: directed vector table, flush/reset corner sequences and
// randomized transactions checked against a transaction-level expectation queue.
module tb_ibex_rf_cache_fill_ctrl;

    localparam int CacheLen  = 16;
    localparam int DataWidth = 32;

    logic        clk_i;
    logic        rst_ni;
    logic        miss_a_i, miss_b_i, wmiss_i;
    logic [4:0]  addr_a_i, addr_b_i, waddr_i;
    logic [31:0] wdata_i;
    logic        bk_req_o;
    logic [4:0]  bk_addr_o;
    logic        bk_rvalid_i;
    logic [31:0] bk_rdata_i;
    logic        cw_en_o;
    logic [3:0]  cw_way_o;
    logic [4:0]  cw_tag_o;
    logic [31:0] cw_data_o;
    logic        flush_i;
    logic        stall_o;

    ibex_rf_cache_fill_ctrl #(.CacheLen(CacheLen), .DataWidth(DataWidth)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .miss_a_i(miss_a_i), .addr_a_i(addr_a_i),
        .miss_b_i(miss_b_i), .addr_b_i(addr_b_i),
        .wmiss_i(wmiss_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .bk_req_o(bk_req_o), .bk_addr_o(bk_addr_o),
        .bk_rvalid_i(bk_rvalid_i), .bk_rdata_i(bk_rdata_i),
        .cw_en_o(cw_en_o), .cw_way_o(cw_way_o), .cw_tag_o(cw_tag_o), .cw_data_o(cw_data_o),
        .flush_i(flush_i), .stall_o(stall_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          a_v, b_v, w_v, spur, tbl;
        logic [4:0]  a, b, wa;
        logic [31:0] wd, rdata;
        int          lat, exp_req, exp_cw;
    } vec_t;

    typedef struct {
        bit          is_w;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    int checks   = 0;
    int failures = 0;
    int exp_way  = 0;
    int n_req_seen, n_cw_seen;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_req();
        miss_a_i = 1'b0; miss_b_i = 1'b0; wmiss_i = 1'b0;
        addr_a_i = 5'd0; addr_b_i = 5'd0; waddr_i = 5'd0; wdata_i = 32'd0;
    endtask

    // Called after inputs are driven at the falling edge; samples mid-cycle.
    task automatic sample(input bit es, input bit er, input logic [4:0] ea, input bit ec,
                          input logic [4:0] et, input logic [31:0] ed, input int ew, input string nm);
        #1;
        chk({nm, ":stall"}, stall_o, es);
        chk({nm, ":bk_req"}, bk_req_o, er);
        if (er) chk({nm, ":bk_addr"}, bk_addr_o, ea);
        chk({nm, ":cw_en"}, cw_en_o, ec);
        if (ec) begin
            chk({nm, ":cw_tag"}, cw_tag_o, et);
            chk({nm, ":cw_data"}, cw_data_o, ed);
            chk({nm, ":cw_way"}, cw_way_o, ew);
        end
        n_req_seen += int'(bk_req_o);
        n_cw_seen  += int'(cw_en_o);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        flush_i = 1'b0; bk_rvalid_i = 1'b0; bk_rdata_i = 32'd0;
        miss_a_i = 1'b1; addr_a_i = 5'd5; wmiss_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'h55;
        #1;
        chk("rst:stall", stall_o, 1'b0);
        chk("rst:bk_req", bk_req_o, 1'b0);
        chk("rst:bk_addr", bk_addr_o, 5'd0);
        chk("rst:cw_en", cw_en_o, 1'b0);
        chk("rst:cw_way", cw_way_o, 4'd0);
        chk("rst:cw_tag", cw_tag_o, 5'd0);
        chk("rst:cw_data", cw_data_o, 32'd0);
        @(negedge clk_i);
        clear_req();
        rst_ni  = 1'b1;
        exp_way = 0;
    endtask

    task automatic run_txn(input vec_t v);
        ent_t q[$];
        ent_t e;
        int   n_reads;
        logic [31:0] rd;
        n_reads = 0;
        if (v.a_v && v.a != 5'd0) begin
            e = '{is_w: 1'b0, addr: v.a, data: 32'd0}; q.push_back(e); n_reads++;
        end
        if (v.b_v && v.b != 5'd0 && !(v.a_v && v.a != 5'd0 && v.a == v.b)) begin
            e = '{is_w: 1'b0, addr: v.b, data: 32'd0}; q.push_back(e); n_reads++;
        end
        if (v.w_v && v.wa != 5'd0) begin
            e = '{is_w: 1'b1, addr: v.wa, data: v.wd}; q.push_back(e);
        end
        n_req_seen = 0;
        n_cw_seen  = 0;
        @(negedge clk_i);
        miss_a_i = v.a_v; addr_a_i = v.a; miss_b_i = v.b_v; addr_b_i = v.b;
        wmiss_i = v.w_v; waddr_i = v.wa; wdata_i = v.wd;
        sample(q.size() != 0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 0, "capture");
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk_i);
            clear_req();
            if (!q[k].is_w) begin
                rd = v.rdata + 32'(k);
                bk_rvalid_i = v.spur; bk_rdata_i = ~rd;
                sample(1'b1, 1'b1, q[k].addr, 1'b0, 5'd0, 32'd0, 0, "bkreq");
                for (int d = 1; d <= v.lat; d++) begin
                    @(negedge clk_i);
                    bk_rvalid_i = (d == v.lat);
                    bk_rdata_i  = (d == v.lat) ? rd : ~rd;
                    sample(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 0, "wait");
                end
                @(negedge clk_i);
                bk_rvalid_i = 1'b0; bk_rdata_i = ~rd;
                sample(1'b1, 1'b0, 5'd0, 1'b1, q[k].addr, rd, exp_way, "rfill");
            end else begin
                sample(1'b1, 1'b0, 5'd0, 1'b1, q[k].addr, q[k].data, exp_way, "wfill");
            end
            exp_way = (exp_way + 1) % CacheLen;
        end
        @(negedge clk_i);
        clear_req();
        sample(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 0, "done");
        chk("req_count", n_req_seen, v.tbl ? v.exp_req : n_reads);
        chk("cw_count", n_cw_seen, v.tbl ? v.exp_cw : q.size());
    endtask

    // Abandon a read fill in WAIT either by flush or by asserting reset.
    task automatic abandon_in_wait(input bit use_rst);
        @(negedge clk_i);
        miss_a_i = 1'b1; addr_a_i = 5'd10;
        sample(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 0, "ab_cap");
        @(negedge clk_i);
        clear_req();
        sample(1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 32'd0, 0, "ab_req");
        @(negedge clk_i);
        if (use_rst) rst_ni = 1'b0; else flush_i = 1'b1;
        sample(!use_rst, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 0, "ab_wait");
        @(negedge clk_i);
        rst_ni = 1'b1; flush_i = 1'b0;
        bk_rvalid_i = 1'b1; bk_rdata_i = 32'h1234_5678;
        if (use_rst) exp_way = 0;
        sample(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 0, "ab_after");
        @(negedge clk_i);
        bk_rvalid_i = 1'b0;
        sample(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 0, "ab_quiet");
    endtask

    initial begin
        vec_t v;
        rst_ni = 1'b0; flush_i = 1'b0; bk_rvalid_i = 1'b0; bk_rdata_i = 32'd0;
        clear_req();

        tbl[0] = '{a_v:1, b_v:0, w_v:0, spur:0, tbl:1, a:5'd5, b:5'd0, wa:5'd0, wd:32'h0,
                   rdata:32'hDEAD_BEEF, lat:1, exp_req:1, exp_cw:1};
        tbl[1] = '{a_v:1, b_v:1, w_v:1, spur:0, tbl:1, a:5'd3, b:5'd7, wa:5'd9, wd:32'h11,
                   rdata:32'hA000_0000, lat:1, exp_req:2, exp_cw:3};
        tbl[2] = '{a_v:1, b_v:1, w_v:0, spur:0, tbl:1, a:5'd4, b:5'd4, wa:5'd0, wd:32'h0,
                   rdata:32'h4444_0000, lat:1, exp_req:1, exp_cw:1};
        tbl[3] = '{a_v:1, b_v:0, w_v:0, spur:0, tbl:1, a:5'd0, b:5'd0, wa:5'd0, wd:32'h0,
                   rdata:32'h0, lat:1, exp_req:0, exp_cw:0};
        tbl[4] = '{a_v:1, b_v:1, w_v:0, spur:1, tbl:1, a:5'd0, b:5'd6, wa:5'd0, wd:32'h0,
                   rdata:32'h0606_0606, lat:3, exp_req:1, exp_cw:1};
        tbl[5] = '{a_v:0, b_v:0, w_v:1, spur:0, tbl:1, a:5'd0, b:5'd0, wa:5'd12, wd:32'hCAFE,
                   rdata:32'h0, lat:1, exp_req:0, exp_cw:1};
        tbl[6] = '{a_v:1, b_v:0, w_v:1, spur:1, tbl:1, a:5'd8, b:5'd0, wa:5'd8, wd:32'h88,
                   rdata:32'h8080_0000, lat:2, exp_req:1, exp_cw:2};
        tbl[7] = '{a_v:0, b_v:1, w_v:1, spur:0, tbl:1, a:5'd0, b:5'd2, wa:5'd0, wd:32'h77,
                   rdata:32'h2222_0000, lat:1, exp_req:1, exp_cw:1};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_reset();
            run_txn(tbl[i]);
        end

        // Seventeen single misses from reset walk the victim pointer through a full wrap.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            v = '{a_v:1, b_v:0, w_v:0, spur:0, tbl:0, a:5'(i + 1), b:5'd0, wa:5'd0, wd:32'h0,
                  rdata:32'(i * 7 + 1), lat:1, exp_req:0, exp_cw:0};
            run_txn(v);
        end

        abandon_in_wait(1'b0);
        v = '{a_v:0, b_v:0, w_v:1, spur:0, tbl:1, a:5'd0, b:5'd0, wa:5'd20, wd:32'hF00D,
              rdata:32'h0, lat:1, exp_req:0, exp_cw:1};
        run_txn(v);
        abandon_in_wait(1'b1);
        run_txn(v);

        for (int i = 0; i < 250; i++) begin
            v.a_v = 1'($urandom); v.b_v = 1'($urandom); v.w_v = 1'($urandom);
            v.spur = 1'($urandom); v.tbl = 1'b0;
            v.a = 5'($urandom_range(0, 7)); v.b = 5'($urandom_range(0, 7));
            v.wa = 5'($urandom_range(0, 31));
            v.wd = $urandom; v.rdata = $urandom;
            v.lat = int'($urandom_range(1, 3));
            v.exp_req = 0; v.exp_cw = 0;
            run_txn(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ibex_rf_cache_fill_ctrl.md
IBEX_RF_CACHE_FILL_CTRL -- requirements
Module: ibex_rf_cache_fill_ctrl

Interface
REQ-001 SHALL have parameter CacheLen, default 16, number of cache ways; power of two, 2..16.
REQ-002 SHALL have parameter DataWidth, default 32, register data width.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports miss_a_i/miss_b_i, input, 1 each, read-port A/B cache miss request.
REQ-006 SHALL have ports addr_a_i/addr_b_i, input, 5 each, register address of the A/B miss.
REQ-007 SHALL have ports wmiss_i (input, 1), waddr_i (input, 5) and wdata_i (input, DataWidth), write-port miss with data.
REQ-008 SHALL have ports bk_req_o (output, 1) and bk_addr_o (output, 5), backing-register-file read request.
REQ-009 SHALL have ports bk_rvalid_i (input, 1) and bk_rdata_i (input, DataWidth), backing read response.
REQ-010 SHALL have ports cw_en_o (output, 1), cw_way_o (output, $clog2(CacheLen)), cw_tag_o (output, 5) and cw_data_o (output, DataWidth), cache line write.
REQ-011 SHALL have port flush_i, input, 1, abandon all pending and in-flight fills.
REQ-012 SHALL have port stall_o, output, 1, pipeline stall while any request is pending or in flight.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, WAIT and FILL.
REQ-014 SHALL capture miss_a_i/miss_b_i/wmiss_i into a 3-entry pending set only in IDLE with stall_o low; requests at other times are ignored, since the requester holds them until stall_o drops.
REQ-015 SHALL drop any request whose address is 0.
REQ-016 SHALL merge B into A when both are captured with addr_a_i == addr_b_i, giving one fill.
REQ-017 SHALL service pending entries in fixed priority A > B > W, one at a time.
REQ-018 SHALL assert stall_o combinationally in the same cycle as any valid captured request, and hold it until the cycle after the last cw_en_o.
REQ-019 For a read entry, SHALL transition IDLE/FILL -> REQ, drive bk_req_o=1 for exactly one cycle with bk_addr_o = the entry address, then enter WAIT.
REQ-020 In WAIT, SHALL stay until bk_rvalid_i=1, then enter FILL and register bk_rdata_i.
REQ-021 In FILL, SHALL drive cw_en_o=1 for one cycle with cw_tag_o = address, cw_data_o = the registered data and cw_way_o = the victim pointer.
REQ-022 For a W entry, SHALL skip REQ/WAIT and go directly to FILL with cw_data_o = the captured wdata_i (write-allocate).
REQ-023 SHALL increment the victim pointer by 1 after every cw_en_o, wrapping from CacheLen-1 to 0.
REQ-024 After FILL, SHALL go to REQ/FILL for the next pending entry, or to IDLE if none remain.
REQ-025 Minimum read-fill latency SHALL be 3 cycles from capture to cw_en_o when bk_rvalid_i returns the cycle after bk_req_o; a W-only fill SHALL take 1 cycle.
REQ-026 On flush_i=1 in any state, SHALL clear all pending entries and go to IDLE next cycle, with no cw_en_o for abandoned entries; the victim pointer is unchanged.
REQ-027 SHALL ignore bk_rvalid_i outside WAIT.

Reset
REQ-028 While rst_ni=0, SHALL hold the FSM in IDLE, clear the pending set and set the victim pointer to 0.
REQ-029 While rst_ni=0, SHALL hold stall_o, bk_req_o and cw_en_o at 0, and hold bk_addr_o, cw_way_o, cw_tag_o and cw_data_o at 0.
REQ-030 Reset asserted mid-fill SHALL abandon the fill with no cw_en_o afterwards.

Configuration
REQ-031 Macro IBEX_RF_CACHE_PERF_EN defined SHALL add outputs perf_miss_cnt_o[31:0] (counts each cw_en_o) and perf_stall_cnt_o[31:0] (counts cycles with stall_o=1), both reset to 0 and saturating at 32'hFFFFFFFF.
REQ-032 Macro IBEX_RF_CACHE_PERF_EN undefined SHALL leave these ports and counters absent, with all other behaviour identical.

Verification
REQ-033 Single A miss: addr_a_i=5, bk_rvalid_i one cycle after bk_req_o with data 0xDEADBEEF -> bk_addr_o=5, then cw_en_o with tag 5, way 0, data 0xDEADBEEF 3 cycles after capture; stall_o is then 0 on the next cycle.
REQ-034 Simultaneous A=3, B=7, W=9 (wdata 0x11) -> fills in order 3, 7, 9 on ways 0, 1, 2; exactly two bk_req_o pulses.
REQ-035 A=B=4 -> one bk_req_o and one cw_en_o.
REQ-036 Seventeen sequential misses with CacheLen=16 -> cw_way_o runs 0..15, then 0.
REQ-037 flush_i in WAIT, then bk_rvalid_i -> no cw_en_o, stall_o=0 within 1 cycle; rst_ni low in WAIT gives the same result, and the victim pointer is 0 after reset.
REQ-038 Address-0 miss -> no stall_o, no bk_req_o.
